strategy_order_arbiter: RTL and testbench
=========================================

Name: strategy_order_arbiter

Overview:
- Sits between up to N strategy engines and the single order-entry port. Each strategy engine produces 1-cycle signal/qty/side pulses.
- Holds a one-deep pending order per source and grants sources round-robin.
- Runs a pre-trade position-limit check against the live net position and enforces a token-bucket rate limit.
- Presents one order at a time on a valid/ready interface; failed orders are reported on a reject pulse.

Parameters:
- N_STRAT, 4, number of requesting strategy engines (2..8).
- MAX_POS, 1000, absolute net-position limit (signed, inclusive).
- RATE_TOKENS, 4, token-bucket depth (max orders in a burst).
- REFILL_CYCLES, 256, clock cycles per token refill.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- req_signal  in  N_STRAT  per-source order pulse, 1 cycle.
- req_qty  in  32*N_STRAT  per-source quantity, unsigned; source i occupies bits [32i+31:32i].
- req_side  in  N_STRAT  per-source side, 1=BUY, 0=SELL.
- cur_position  in  32  signed live net position.
- kill_switch  in  1  level; blocks all new orders.
- ord_valid  out  1  order presented.
- ord_ready  in  1  order-entry accepts.
- ord_qty  out  32  granted quantity.
- ord_side  out  1  granted side.
- ord_src  out  3  granted source index.
- rej_valid  out  1  1-cycle reject pulse.
- rej_src  out  3  rejected source index.
- rej_reason  out  2  01=position limit, 10=kill, 11=zero qty.
- drop_pulse  out  N_STRAT  request lost because its slot was occupied.
- throttled  out  1  waiting for a token.

Behaviour:
- Reset values:
  - All outputs 0; all slots empty.
  - State IDLE; round-robin pointer 0.
  - Tokens = RATE_TOKENS; refill counter 0.
- Reset is asynchronous and may occur at any time. An order in flight is abandoned with no completion.
- Capture:
  - A req_signal[i] sampled high while slot i is empty (or being cleared that same cycle) latches qty and side. The slot shows valid the next cycle.
  - If the slot is occupied, the request is discarded and drop_pulse[i] is asserted for 1 cycle.
  - While kill_switch=1, no captures occur, and all slots not currently granted are cleared silently.
- FSM states: IDLE, CHECK, SEND.
  - IDLE: if kill_switch=0 and any slot is valid, grant the first valid slot at or after the pointer (round-robin), then go to CHECK. The pointer moves to grant+1 modulo N_STRAT.
  - CHECK: compute projected = cur_position ± qty in 34-bit signed arithmetic (+ for BUY, − for SELL). No truncation.
    - kill_switch=1: reject with reason 10.
    - qty==0: reject with reason 11.
    - |projected| > MAX_POS: reject with reason 01.
    - Reason priority when several apply: kill, then zero, then position.
    - No reject condition but tokens==0: stay in CHECK with throttled=1, and re-evaluate each cycle (position may change meanwhile).
    - Otherwise go to SEND.
    - On any reject: rej_valid=1 for 1 cycle, rej_src=grant, slot cleared, next state IDLE.
  - SEND:
    - ord_valid=1 with ord_qty, ord_side and ord_src stable until ord_ready=1.
    - ord_valid is never retracted, even if kill_switch rises.
    - On handshake: consume 1 token, clear the slot, go to IDLE.
- Latency:
  - Pulse in cycle 0 gives ord_valid=1 in cycle 3 in the best case (tokens available, ready low or high).
  - Minimum spacing between back-to-back orders is 3 cycles.
- Token bucket:
  - The refill counter counts to REFILL_CYCLES−1 and then wraps. On wrap, add 1 token, saturating at RATE_TOKENS.
  - Refill and consume in the same cycle leave the token count unchanged.
- Only the granted slot is protected from kill clearing. It completes through CHECK, where it is rejected.

Decomposition:
- Shared package trading_pkg:
  - side encoding constants (SIDE_BUY=1, SIDE_SELL=0);
  - rej_reason constants;
  - the FSM state typedef.
- One sub-module, order_token_bucket: refill counter, token count, consume input, tokens_avail output.
- Round-robin select stays inline.

Test Plan:
1. Single BUY: cur_position=0, src 2 qty=100 pulse in cycle 0, ord_ready held 1 → ord_valid in cycle 3 with qty=100, side=1, src=2. Exactly one token consumed (4→3).
2. Round-robin: srcs 0, 1, 3 pulse in the same cycle → orders granted in source order 0, 1, 3, each accepted. Then a src 0 and src 3 pulse → src 0 granted first, since the pointer wrapped.
3. Position limit:
   - cur_position=950, BUY qty=100 → rej_valid with reason 01; no ord_valid.
   - cur_position=950, SELL qty=100 → order sent.
   - cur_position=900, BUY qty=100 (projected exactly 1000) → order sent.
4. Rate limit: RATE_TOKENS=4, REFILL_CYCLES=256, 5 orders back-to-back with ready=1 → 4 orders sent; the 5th holds throttled=1 until the refill wrap, then is sent.
5. Backpressure and drop:
   - ord_ready=0 for 10 cycles → ord_valid and payload held stable.
   - A second pulse from the same source during that time → drop_pulse asserted, request not queued.
6. Kill and reset:
   - kill_switch asserted while an order is in SEND → that order still completes.
   - Pending slots are cleared with no rejects; new pulses are ignored.
   - rstn low mid-SEND → all outputs return to 0 and tokens are full again after release.

Source files
------------

// File: rtl/trading_pkg.sv
// Shared encodings for the strategy order arbiter: side values, reject reasons
// and the arbiter FSM state type.
package trading_pkg;

   localparam logic SIDE_BUY  = 1'b1;
   localparam logic SIDE_SELL = 1'b0;

   localparam logic [1:0] REJ_NONE = 2'b00;
   localparam logic [1:0] REJ_POS  = 2'b01;
   localparam logic [1:0] REJ_KILL = 2'b10;
   localparam logic [1:0] REJ_ZERO = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      SEND
   } arb_state_t;

endpackage

// File: rtl/order_token_bucket.sv
// Token-bucket rate limiter: one token is added every REFILL_CYCLES clocks,
// saturating at RATE_TOKENS; each accepted order consumes one token.
module order_token_bucket #(
   parameter int RATE_TOKENS   = 4,
   parameter int REFILL_CYCLES = 256
) (
   input  logic clk,
   input  logic rstn,
   input  logic consume,
   output logic tokens_avail
);

   localparam int TOK_W = $clog2(RATE_TOKENS + 1);
   localparam int CNT_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;

   logic [CNT_W-1:0] refill_cnt;
   logic [TOK_W-1:0] tokens;
   logic             wrap;
   logic             take;

   assign wrap         = (refill_cnt == CNT_W'(REFILL_CYCLES - 1));
   assign tokens_avail = (tokens != '0);
   assign take         = consume && tokens_avail;

   // A refill and a consume landing on the same edge cancel out.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         refill_cnt <= '0;
         tokens     <= TOK_W'(RATE_TOKENS);
      end else begin
         refill_cnt <= wrap ? '0 : refill_cnt + 1'b1;
         if (wrap && !take && (tokens != TOK_W'(RATE_TOKENS)))
            tokens <= tokens + 1'b1;
         else if (take && !wrap)
            tokens <= tokens - 1'b1;
      end
   end

endmodule

// File: rtl/strategy_order_arbiter.sv
// Arbitrates one-deep order slots from N_STRAT strategy engines onto a single
// valid/ready order port, with pre-trade position and rate limiting.
module strategy_order_arbiter
   import trading_pkg::*;
#(
   parameter int N_STRAT       = 4,
   parameter int MAX_POS       = 1000,
   parameter int RATE_TOKENS   = 4,
   parameter int REFILL_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [N_STRAT-1:0]      req_signal,
   input  logic [32*N_STRAT-1:0]   req_qty,
   input  logic [N_STRAT-1:0]      req_side,
   input  logic signed [31:0]      cur_position,
   input  logic                    kill_switch,
   output logic                    ord_valid,
   input  logic                    ord_ready,
   output logic [31:0]             ord_qty,
   output logic                    ord_side,
   output logic [2:0]              ord_src,
   output logic                    rej_valid,
   output logic [2:0]              rej_src,
   output logic [1:0]              rej_reason,
   output logic [N_STRAT-1:0]      drop_pulse,
   output logic                    throttled
);

   localparam int IDX_W = $clog2(N_STRAT);
   localparam logic signed [33:0] POS_LIM = 34'(MAX_POS);

   arb_state_t          state, state_next;
   logic [IDX_W-1:0]    grant, grant_next;
   logic [IDX_W-1:0]    rr_ptr, rr_ptr_next;
   logic [N_STRAT-1:0]  slot_valid, slot_side, slot_clr, slot_held;
   logic [31:0]         slot_qty [N_STRAT];
   logic                sel_found;
   logic [IDX_W-1:0]    sel_idx, cand;
   logic [31:0]         grant_qty;
   logic                grant_side;
   logic signed [33:0]  cur_ext, qty_ext, projected;
   logic [1:0]          reason;
   logic                tokens_avail, consume;

   order_token_bucket #(
      .RATE_TOKENS  (RATE_TOKENS),
      .REFILL_CYCLES(REFILL_CYCLES)
   ) u_bucket (
      .clk         (clk),
      .rstn        (rstn),
      .consume     (consume),
      .tokens_avail(tokens_avail)
   );

   assign grant_qty  = slot_qty[grant];
   assign grant_side = slot_side[grant];
   assign cur_ext    = {{2{cur_position[31]}}, cur_position};
   assign qty_ext    = {2'b00, grant_qty};
   assign projected  = (grant_side == SIDE_BUY) ? cur_ext + qty_ext : cur_ext - qty_ext;

   always_comb begin
      reason = REJ_NONE;
      if (kill_switch)
         reason = REJ_KILL;
      else if (grant_qty == '0)
         reason = REJ_ZERO;
      else if ((projected > POS_LIM) || (projected < -POS_LIM))
         reason = REJ_POS;
   end

   // First valid slot at or after the round-robin pointer.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 0; k < N_STRAT; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % N_STRAT);
         if (!sel_found && slot_valid[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_STRAT; i++)
         slot_held[i] = (state != IDLE) && (grant == IDX_W'(i));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_next;
         grant  <= grant_next;
         rr_ptr <= rr_ptr_next;
      end
   end

   always_comb begin
      state_next  = state;
      grant_next  = grant;
      rr_ptr_next = rr_ptr;
      consume     = 1'b0;
      slot_clr    = '0;
      ord_valid   = 1'b0;
      ord_qty     = '0;
      ord_side    = SIDE_SELL;
      ord_src     = '0;
      rej_valid   = 1'b0;
      rej_src     = '0;
      rej_reason  = REJ_NONE;
      throttled   = 1'b0;
      case (state)
         IDLE: begin
            if (!kill_switch && sel_found) begin
               grant_next  = sel_idx;
               rr_ptr_next = (sel_idx == IDX_W'(N_STRAT - 1)) ? '0 : sel_idx + 1'b1;
               state_next  = CHECK;
            end
         end
         CHECK: begin
            if (reason != REJ_NONE) begin
               rej_valid       = 1'b1;
               rej_src         = 3'(grant);
               rej_reason      = reason;
               slot_clr[grant] = 1'b1;
               state_next      = IDLE;
            end else if (!tokens_avail) begin
               throttled = 1'b1;
            end else begin
               state_next = SEND;
            end
         end
         SEND: begin
            ord_valid = 1'b1;
            ord_qty   = grant_qty;
            ord_side  = grant_side;
            ord_src   = 3'(grant);
            if (ord_ready) begin
               consume         = 1'b1;
               slot_clr[grant] = 1'b1;
               state_next      = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Kill wipes every slot except the one already in flight, which finishes
   // through CHECK (rejected) or SEND (completed).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slot_valid <= '0;
         slot_side  <= '0;
         drop_pulse <= '0;
         for (int i = 0; i < N_STRAT; i++)
            slot_qty[i] <= '0;
      end else begin
         drop_pulse <= '0;
         for (int i = 0; i < N_STRAT; i++) begin
            if (kill_switch) begin
               if (!slot_held[i] || slot_clr[i])
                  slot_valid[i] <= 1'b0;
            end else if (req_signal[i]) begin
               if (!slot_valid[i] || slot_clr[i]) begin
                  slot_valid[i] <= 1'b1;
                  slot_qty[i]   <= req_qty[32*i +: 32];
                  slot_side[i]  <= req_side[i];
               end else begin
                  drop_pulse[i] <= 1'b1;
               end
            end else if (slot_clr[i]) begin
               slot_valid[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_strategy_order_arbiter.sv
// Self-checking bench for strategy_order_arbiter: directed scenarios with
// literal expectations plus a randomized run against a transaction-level model.
module tb_strategy_order_arbiter;

   localparam int N       = 4;
   localparam int MAXP    = 1000;
   localparam int RATE    = 4;
   localparam int REFILL  = 256;

   logic                 clk = 1'b0;
   logic                 rstn = 1'b0;
   logic [N-1:0]         req_signal = '0;
   logic [32*N-1:0]      req_qty = '0;
   logic [N-1:0]         req_side = '0;
   logic signed [31:0]   cur_position = '0;
   logic                 kill_switch = 1'b0;
   logic                 ord_valid;
   logic                 ord_ready = 1'b0;
   logic [31:0]          ord_qty;
   logic                 ord_side;
   logic [2:0]           ord_src;
   logic                 rej_valid;
   logic [2:0]           rej_src;
   logic [1:0]           rej_reason;
   logic [N-1:0]         drop_pulse;
   logic                 throttled;

   strategy_order_arbiter #(
      .N_STRAT(N), .MAX_POS(MAXP), .RATE_TOKENS(RATE), .REFILL_CYCLES(REFILL)
   ) dut (
      .clk(clk), .rstn(rstn), .req_signal(req_signal), .req_qty(req_qty),
      .req_side(req_side), .cur_position(cur_position), .kill_switch(kill_switch),
      .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_qty(ord_qty),
      .ord_side(ord_side), .ord_src(ord_src), .rej_valid(rej_valid),
      .rej_src(rej_src), .rej_reason(rej_reason), .drop_pulse(drop_pulse),
      .throttled(throttled)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int reset_cyc = 0;

   // Reference model: 0 = waiting for work, 1 = vetting an order, 2 = presenting it.
   bit           m_valid [N];
   int unsigned  m_qty [N];
   bit           m_side [N];
   int           m_stage, m_grant, m_ptr, m_tokens, m_cnt;
   bit [N-1:0]   m_drop;

   int           acc_log [$];
   int           acc_cyc [$];
   int           rej_log [$];
   int           drop_count;
   bit           throttle_seen;
   logic         snap_ov;
   logic [31:0]  snap_qty;
   logic         snap_side;
   logic [2:0]   snap_src;

   task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0; m_qty[i] = 0; m_side[i] = 0;
      end
      m_stage = 0; m_grant = 0; m_ptr = 0; m_tokens = RATE; m_cnt = 0; m_drop = '0;
   endtask

   function automatic int model_reason();
      longint proj;
      if (kill_switch) return 2;
      if (m_qty[m_grant] == 0) return 3;
      proj = m_side[m_grant] ? longint'(cur_position) + longint'(m_qty[m_grant])
                             : longint'(cur_position) - longint'(m_qty[m_grant]);
      if (proj > MAXP || proj < -MAXP) return 1;
      return 0;
   endfunction

   task automatic model_update();
      int rsn = model_reason();
      bit [N-1:0] clr = '0;
      bit [N-1:0] held = '0;
      bit take = 0;
      bit refill;
      if (m_stage != 0) held[m_grant] = 1;
      if (m_stage == 1 && rsn != 0) clr[m_grant] = 1;
      if (m_stage == 2 && ord_ready) begin clr[m_grant] = 1; take = 1; end
      case (m_stage)
         0: if (!kill_switch) begin
               for (int k = 0; k < N; k++) begin
                  int s = (m_ptr + k) % N;
                  if (m_valid[s]) begin
                     m_grant = s; m_ptr = (s + 1) % N; m_stage = 1;
                     break;
                  end
               end
            end
         1: if (rsn != 0) m_stage = 0; else if (m_tokens > 0) m_stage = 2;
         default: if (ord_ready) m_stage = 0;
      endcase
      m_drop = '0;
      for (int i = 0; i < N; i++) begin
         if (kill_switch) begin
            if (!held[i] || clr[i]) m_valid[i] = 0;
         end else if (req_signal[i]) begin
            if (!m_valid[i] || clr[i]) begin
               m_valid[i] = 1; m_qty[i] = req_qty[32*i +: 32]; m_side[i] = req_side[i];
            end else m_drop[i] = 1;
         end else if (clr[i]) m_valid[i] = 0;
      end
      refill = (m_cnt == REFILL - 1);
      m_cnt = refill ? 0 : m_cnt + 1;
      if (refill && !take) m_tokens = (m_tokens < RATE) ? m_tokens + 1 : RATE;
      else if (take && !refill) m_tokens = m_tokens - 1;
   endtask

   // Per-cycle comparison of every output against the model, plus logging.
   task automatic check_output();
      int rsn = (m_stage == 1) ? model_reason() : 0;
      bit ev = (m_stage == 2);
      bit rv = (m_stage == 1) && (rsn != 0);
      expect_eq("ord_bundle", {ord_valid, ord_qty, ord_side, ord_src},
                {ev, ev ? 32'(m_qty[m_grant]) : 32'd0, ev ? m_side[m_grant] : 1'b0,
                 ev ? 3'(m_grant) : 3'd0});
      expect_eq("rej_bundle", {rej_valid, rej_src, rej_reason},
                {rv, rv ? 3'(m_grant) : 3'd0, rv ? 2'(rsn) : 2'd0});
      expect_eq("throttled", throttled, (m_stage == 1) && (rsn == 0) && (m_tokens == 0));
      expect_eq("drop_pulse", drop_pulse, m_drop);
      snap_ov = ord_valid; snap_qty = ord_qty; snap_side = ord_side; snap_src = ord_src;
      if (ord_valid && ord_ready) begin acc_log.push_back(int'(ord_src)); acc_cyc.push_back(cyc); end
      if (rej_valid) rej_log.push_back(int'(rej_src) * 4 + int'(rej_reason));
      if (drop_pulse != '0) drop_count++;
      if (throttled) throttle_seen = 1;
   endtask

   task automatic tick();
      @(negedge clk);
      check_output();
      @(posedge clk);
      if (!rstn) model_reset(); else model_update();
      cyc++;
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic clear_logs();
      acc_log.delete(); acc_cyc.delete(); rej_log.delete();
      drop_count = 0; throttle_seen = 0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      model_reset();
      run(2);
      rstn = 1'b1;
      reset_cyc = cyc;
      clear_logs();
   endtask

   task automatic apply_stimulus(input logic [N-1:0] mask, input logic [31:0] qty, input logic side);
      req_signal = mask;
      for (int i = 0; i < N; i++) begin
         req_qty[32*i +: 32] = qty;
         req_side[i] = side;
      end
      tick();
      req_signal = '0;
   endtask

   task automatic wait_acc(input int n, input int budget, input string name);
      int b = 0;
      while (acc_log.size() < n && b < budget) begin tick(); b++; end
      expect_eq(name, acc_log.size(), n);
   endtask

   function automatic logic [31:0] pick_qty();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'($urandom_range(1, 200));
         2: return 32'hFFFF_FFFF;
         3: return $urandom;
         default: return 32'($urandom_range(1, 2000));
      endcase
   endfunction

   initial begin
      model_reset();

      // Single BUY: best-case latency of three cycles, one token consumed.
      do_reset();
      expect_eq("reset_tokens", dut.u_bucket.tokens, 4);
      ord_ready = 1'b1; cur_position = 0;
      apply_stimulus(4'b0100, 32'd100, 1'b1);
      run(2);
      expect_eq("t1_not_early", snap_ov, 0);
      run(1);
      expect_eq("t1_order", {snap_ov, snap_qty, snap_side, snap_src}, {1'b1, 32'd100, 1'b1, 3'd2});
      expect_eq("t1_tokens", dut.u_bucket.tokens, 3);

      // Round-robin ordering, including pointer wrap.
      do_reset();
      apply_stimulus(4'b1011, 32'd10, 1'b1);
      wait_acc(3, 20, "t2_three_sent");
      expect_eq("t2_order", {acc_log[0][2:0], acc_log[1][2:0], acc_log[2][2:0]}, {3'd0, 3'd1, 3'd3});
      apply_stimulus(4'b1001, 32'd10, 1'b0);
      wait_acc(5, 400, "t2_pair_sent");
      expect_eq("t2_wrap_first", acc_log[3], 0);

      // Position limit, inclusive at exactly MAX_POS.
      do_reset();
      cur_position = 950;
      apply_stimulus(4'b0001, 32'd100, 1'b1);
      run(6);
      expect_eq("t3_reject", {rej_log.size(), acc_log.size()}, {32'd1, 32'd0});
      expect_eq("t3_reason", rej_log[0], 0 * 4 + 1);
      apply_stimulus(4'b0010, 32'd100, 1'b0);
      wait_acc(1, 20, "t3_sell_sent");
      cur_position = 900;
      apply_stimulus(4'b0100, 32'd100, 1'b1);
      wait_acc(2, 20, "t3_edge_sent");
      expect_eq("t3_no_more_rej", rej_log.size(), 1);

      // Rate limit: the fifth order waits for the refill.
      do_reset();
      cur_position = 0;
      apply_stimulus(4'b1111, 32'd5, 1'b1);
      run(4);
      apply_stimulus(4'b0001, 32'd5, 1'b1);
      wait_acc(4, 30, "t4_burst");
      run(10);
      expect_eq("t4_held", {acc_log.size(), 31'd0, throttle_seen}, {32'd4, 31'd0, 1'b1});
      wait_acc(5, 300, "t4_fifth");
      if (acc_cyc.size() == 5)
         expect_eq("t4_after_refill", (acc_cyc[4] - reset_cyc) >= 255, 1);

      // Backpressure holds the payload; a repeat pulse is dropped.
      do_reset();
      ord_ready = 1'b0;
      apply_stimulus(4'b0010, 32'd77, 1'b0);
      run(5);
      apply_stimulus(4'b0010, 32'd88, 1'b1);
      run(5);
      expect_eq("t5_held", {snap_ov, snap_qty, snap_side, snap_src}, {1'b1, 32'd77, 1'b0, 3'd1});
      expect_eq("t5_drop", drop_count, 1);
      ord_ready = 1'b1;
      run(12);
      expect_eq("t5_one_order", acc_log.size(), 1);

      // Kill during SEND: in-flight order completes, pending slots vanish quietly.
      do_reset();
      ord_ready = 1'b0;
      apply_stimulus(4'b0001, 32'd20, 1'b1);
      run(2);
      apply_stimulus(4'b1100, 32'd30, 1'b1);
      kill_switch = 1'b1;
      apply_stimulus(4'b0010, 32'd40, 1'b1);
      run(3);
      expect_eq("t6_still_valid", {snap_ov, snap_src}, {1'b1, 3'd0});
      ord_ready = 1'b1;
      wait_acc(1, 5, "t6_completes");
      run(5);
      kill_switch = 1'b0;
      run(15);
      expect_eq("t6_quiet", {acc_log.size(), rej_log.size()}, {32'd1, 32'd0});

      // Asynchronous reset in the middle of SEND.
      ord_ready = 1'b0;
      apply_stimulus(4'b0010, 32'd15, 1'b1);
      run(3);
      #2 rstn = 1'b0;
      #1;
      expect_eq("t6_async_clear", {ord_valid, ord_qty, ord_src, rej_valid, throttled}, '0);
      model_reset();
      run(2);
      rstn = 1'b1;
      run(2);
      expect_eq("t6_tokens_full", dut.u_bucket.tokens, 4);

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         req_signal = 4'($urandom & $urandom);
         for (int i = 0; i < N; i++) begin
            req_qty[32*i +: 32] = pick_qty();
            req_side[i] = 1'($urandom);
         end
         if ($urandom_range(0, 9) == 0)
            cur_position = ($urandom_range(0, 19) == 0) ? 32'sh7FFF_FFFF
                                                        : 32'($urandom_range(0, 2400)) - 32'sd1200;
         if (kill_switch) kill_switch = ($urandom_range(0, 4) != 0);
         else kill_switch = ($urandom_range(0, 99) < 2);
         ord_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
